// File: rtl/iob_timer_multi.sv
// Multi-channel timer: N_CH counters sharing one programmable prescaler tick,
// each with compare, free-run/periodic/one-shot modes, sample strobe and flags.
module iob_timer_multi #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PRESC_W = 16
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic                     cke_i,
  input  logic [PRESC_W-1:0]       presc_i,
  input  logic [N_CH-1:0]          en_i,
  input  logic [N_CH-1:0]          clr_i,
  input  logic [2*N_CH-1:0]        mode_i,
  input  logic [N_CH*DATA_W-1:0]   cmp_i,
  input  logic [N_CH-1:0]          rstrb_i,
  output logic [N_CH*DATA_W-1:0]   time_o,
  output logic [N_CH-1:0]          match_o,
  output logic [N_CH-1:0]          done_o,
  output logic [N_CH-1:0]          ovf_o
);

  localparam int unsigned TIME_W = N_CH * DATA_W;

  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;

  logic [PRESC_W-1:0] pcnt_q;
  logic [PRESC_W-1:0] pcnt_d;
  logic               any_en_c;
  logic               tick_c;

  logic [DATA_W-1:0]  cnt_q [N_CH];
  logic [DATA_W-1:0]  cnt_d [N_CH];
  logic [N_CH-1:0]    done_d;
  logic [N_CH-1:0]    ovf_d;
  logic [N_CH-1:0]    match_d;
  logic [TIME_W-1:0]  time_d;

  // Shared prescaler; >= keeps it sane when presc_i is lowered mid-count.
  always_comb begin
    any_en_c = |en_i;
    tick_c   = any_en_c && (pcnt_q >= presc_i);
    pcnt_d   = pcnt_q;
    if (!any_en_c || tick_c) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end
  end

  // Per-channel next state: clear beats tick, tick beats hold.
  always_comb begin
    cnt_d   = cnt_q;
    done_d  = done_o;
    ovf_d   = ovf_o;
    match_d = '0;
    time_d  = time_o;
    for (int k = 0; k < N_CH; k++) begin : g_ch
      logic [DATA_W-1:0] cmp_v;
      logic [1:0]        mode_v;
      logic              hit;
      cmp_v  = cmp_i[k*DATA_W +: DATA_W];
      mode_v = mode_i[2*k +: 2];
      hit    = (cnt_q[k] == cmp_v);
      if (rstrb_i[k]) begin
        time_d[k*DATA_W +: DATA_W] = cnt_q[k];
      end
      if (clr_i[k]) begin
        cnt_d[k]  = '0;
        done_d[k] = 1'b0;
        ovf_d[k]  = 1'b0;
      end else if (tick_c && en_i[k] && !done_o[k]) begin
        match_d[k] = hit;
        if (mode_v == MODE_PERIODIC) begin
          cnt_d[k] = hit ? '0 : cnt_q[k] + DATA_W'(1);
        end else if (mode_v == MODE_ONESHOT) begin
          if (hit) begin
            done_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + DATA_W'(1);
          end
        end else begin
          cnt_d[k] = cnt_q[k] + DATA_W'(1);
          if (&cnt_q[k]) begin
            ovf_d[k] = 1'b1;
          end
        end
      end
    end
  end

  // State registers; cke_i low freezes everything but forces match_o low.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pcnt_q  <= '0;
      time_o  <= '0;
      match_o <= '0;
      done_o  <= '0;
      ovf_o   <= '0;
      for (int k = 0; k < N_CH; k++) begin
        cnt_q[k] <= '0;
      end
    end else if (cke_i) begin
      pcnt_q  <= pcnt_d;
      time_o  <= time_d;
      match_o <= match_d;
      done_o  <= done_d;
      ovf_o   <= ovf_d;
      for (int k = 0; k < N_CH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end else begin
      match_o <= '0;
    end
  end

endmodule

// File: tb/tb_iob_timer_multi.sv
// Directed bench for iob_timer_multi: a 32-bit instance for most scenarios and
// an 8-bit instance for the wrap/overflow scenario, sharing the control inputs.
module tb_iob_timer_multi;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned W8 = 8;
  localparam int unsigned PW = 16;

  logic            clk = 1'b0;
  logic            arst_n;
  logic            cke;
  logic [PW-1:0]   presc;
  logic [N-1:0]    en, clr, rstrb;
  logic [2*N-1:0]  mode;
  logic [N*W-1:0]  cmp, time_v;
  logic [N*W8-1:0] cmp8, time8;
  logic [N-1:0]    match_v, done_v, ovf_v;
  logic [N-1:0]    match8, done8, ovf8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iob_timer_multi #(.N_CH(N), .DATA_W(W), .PRESC_W(PW)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .presc_i(presc),
    .en_i(en), .clr_i(clr), .mode_i(mode), .cmp_i(cmp), .rstrb_i(rstrb),
    .time_o(time_v), .match_o(match_v), .done_o(done_v), .ovf_o(ovf_v)
  );

  iob_timer_multi #(.N_CH(N), .DATA_W(W8), .PRESC_W(PW)) dut8 (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .presc_i(presc),
    .en_i(en), .clr_i(clr), .mode_i(mode), .cmp_i(cmp8), .rstrb_i(rstrb),
    .time_o(time8), .match_o(match8), .done_o(done8), .ovf_o(ovf8)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] tm(input int k);
    return time_v[k*W +: W];
  endfunction

  task automatic test_reset();
    arst_n = 1'b0; cke = 1'b1; presc = '0; en = '0; clr = '0; rstrb = '0;
    mode = {2'b00, 2'b10, 2'b01, 2'b00};
    cmp  = {32'h0000_1000, 32'd10, 32'd4, 32'hFFFF_FFF0};
    cmp8 = {8'd250, 8'd10, 8'd4, 8'd250};
    #12;
    checks++; if (time_v !== '0) begin errors++; $display("FAIL reset_time: got %h expected 0", time_v); end
    checks++; if ({match_v, done_v, ovf_v} !== '0) begin errors++; $display("FAIL reset_flags: got %b expected 0", {match_v, done_v, ovf_v}); end
    checks++; if (time8 !== '0) begin errors++; $display("FAIL reset_time8: got %h expected 0", time8); end
    @(posedge clk); #1;
    arst_n = 1'b1;
    step(1);
  endtask

  task automatic test_free_run();
    en = 4'b0001;
    step(1003);
    en = '0; rstrb = 4'b0001;
    step(1);
    rstrb = '0;
    checks++; if (tm(0) !== 32'd1003) begin errors++; $display("FAIL free_run_time0: got %0d expected 1003", tm(0)); end
    for (int k = 1; k < N; k++) begin
      checks++; if (tm(k) !== '0) begin errors++; $display("FAIL free_run_other_time%0d: got %0d expected 0", k, tm(k)); end
    end
  endtask

  task automatic test_periodic();
    presc = 16'd3; en = 4'b0010; rstrb = 4'b0010;
    for (int e = 1; e <= 40; e++) begin
      step(1);
      checks++; if (tm(1) !== W'(((e - 1) / 4) % 5)) begin errors++; $display("FAIL periodic_cnt e=%0d: got %0d expected %0d", e, tm(1), ((e - 1) / 4) % 5); end
      checks++; if (match_v[1] !== (e % 20 == 0)) begin errors++; $display("FAIL periodic_match e=%0d: got %b expected %b", e, match_v[1], (e % 20 == 0)); end
    end
    en = '0; rstrb = '0;
    step(1);
    checks++; if (ovf_v[1] !== 1'b0) begin errors++; $display("FAIL periodic_ovf: got %b expected 0", ovf_v[1]); end
  endtask

  task automatic test_one_shot();
    presc = '0; en = 4'b0100;
    for (int e = 1; e <= 12; e++) begin
      step(1);
      checks++; if (match_v[2] !== (e == 11)) begin errors++; $display("FAIL oneshot_match e=%0d: got %b expected %b", e, match_v[2], (e == 11)); end
      checks++; if (done_v[2] !== (e >= 11)) begin errors++; $display("FAIL oneshot_done e=%0d: got %b expected %b", e, done_v[2], (e >= 11)); end
    end
    step(100);
    rstrb = 4'b0100;
    step(1);
    rstrb = '0;
    checks++; if (tm(2) !== 32'd10) begin errors++; $display("FAIL oneshot_hold: got %0d expected 10", tm(2)); end
    checks++; if (done_v[2] !== 1'b1 || match_v[2] !== 1'b0) begin errors++; $display("FAIL oneshot_sticky: got done=%b match=%b expected done=1 match=0", done_v[2], match_v[2]); end
    clr = 4'b0100;
    step(1);
    clr = '0;
    checks++; if (done_v[2] !== 1'b0) begin errors++; $display("FAIL oneshot_clr_done: got %b expected 0", done_v[2]); end
    step(5);
    rstrb = 4'b0100;
    step(1);
    rstrb = '0; en = '0;
    checks++; if (tm(2) !== 32'd5) begin errors++; $display("FAIL oneshot_resume: got %0d expected 5", tm(2)); end
    step(1);
  endtask

  task automatic test_overflow();
    clr = 4'b1000;
    step(1);
    clr = '0; en = 4'b1000;
    step(255);
    checks++; if (ovf8[3] !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", ovf8[3]); end
    step(1);
    checks++; if (ovf8[3] !== 1'b1) begin errors++; $display("FAIL ovf_wrap: got %b expected 1", ovf8[3]); end
    checks++; if (ovf_v[3] !== 1'b0) begin errors++; $display("FAIL ovf_wide: got %b expected 0", ovf_v[3]); end
    en = '0; rstrb = 4'b1000;
    step(1);
    rstrb = '0;
    checks++; if (time8[3*W8 +: W8] !== 8'd0) begin errors++; $display("FAIL ovf_cnt8: got %0d expected 0", time8[3*W8 +: W8]); end
    checks++; if (tm(3) !== 32'd256) begin errors++; $display("FAIL ovf_cnt32: got %0d expected 256", tm(3)); end
    step(20);
    checks++; if (ovf8[3] !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf8[3]); end
    clr = 4'b1000;
    step(1);
    clr = '0;
    checks++; if (ovf8[3] !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", ovf8[3]); end
  endtask

  task automatic test_clr_strobe_and_async_reset();
    clr = 4'b0001;
    step(1);
    clr = '0; en = 4'b0001;
    step(57);
    en = '0; clr = 4'b0001; rstrb = 4'b0001;
    step(1);
    clr = '0;
    checks++; if (tm(0) !== 32'd57) begin errors++; $display("FAIL clr_strobe_pre: got %0d expected 57", tm(0)); end
    step(1);
    rstrb = '0;
    checks++; if (tm(0) !== 32'd0) begin errors++; $display("FAIL clr_strobe_post: got %0d expected 0", tm(0)); end
    en = 4'b0001;
    step(10);
    #2 arst_n = 1'b0;
    #1;
    checks++; if (time_v !== '0 || time8 !== '0) begin errors++; $display("FAIL async_reset_time: got %h / %h expected 0", time_v, time8); end
    checks++; if ({match_v, done_v, ovf_v, match8, done8, ovf8} !== '0) begin errors++; $display("FAIL async_reset_flags: got %b expected 0", {match_v, done_v, ovf_v, match8, done8, ovf8}); end
    step(2);
    #2 arst_n = 1'b1;
    step(7);
    en = '0; rstrb = 4'b0001;
    step(1);
    rstrb = '0;
    checks++; if (tm(0) !== 32'd7) begin errors++; $display("FAIL reset_restart: got %0d expected 7", tm(0)); end
  endtask

  task automatic test_cke_freeze();
    clr = 4'b0010;
    step(1);
    clr = '0; presc = 16'd3; en = 4'b0010; rstrb = 4'b0010;
    step(18);
    checks++; if (tm(1) !== 32'd4) begin errors++; $display("FAIL cke_pre: got %0d expected 4", tm(1)); end
    cke = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      checks++; if (match_v !== '0 || tm(1) !== 32'd4) begin errors++; $display("FAIL cke_frozen i=%0d: got match=%b time=%0d expected match=0 time=4", i, match_v, tm(1)); end
    end
    checks++; if (done_v !== '0 || ovf_v !== '0) begin errors++; $display("FAIL cke_flags: got done=%b ovf=%b expected 0", done_v, ovf_v); end
    cke = 1'b1;
    step(1);
    checks++; if (match_v[1] !== 1'b0 || tm(1) !== 32'd4) begin errors++; $display("FAIL cke_resume1: got match=%b time=%0d expected match=0 time=4", match_v[1], tm(1)); end
    step(1);
    checks++; if (match_v[1] !== 1'b1 || tm(1) !== 32'd4) begin errors++; $display("FAIL cke_resume2: got match=%b time=%0d expected match=1 time=4", match_v[1], tm(1)); end
    step(1);
    checks++; if (match_v[1] !== 1'b0 || tm(1) !== 32'd0) begin errors++; $display("FAIL cke_resume3: got match=%b time=%0d expected match=0 time=0", match_v[1], tm(1)); end
    en = '0; rstrb = '0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_periodic();
    test_one_shot();
    test_overflow();
    test_clr_strobe_and_async_reset();
    test_cke_freeze();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_timer_multi.md
Name: iob_timer_multi

Overview:
- Multi-channel, parametrised successor to the single free-running timer core.
- Provides N_CH independent counters with:
  - a shared programmable prescaler;
  - per-channel compare, mode (free-run / periodic / one-shot) and sample strobe;
  - match pulse plus sticky done/overflow flags.
- Sits behind the timer CSR block. Its outputs feed software-readable registers and the interrupt aggregator.

Parameters:
- N_CH, 4, number of independent counter channels (1..16).
- DATA_W, 32, counter/compare/sample width per channel (8..64).
- PRESC_W, 16, prescaler divisor width.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- arst_n_i  in  1  asynchronous active-low reset.
- cke_i  in  1  clock enable; low freezes all state.
- presc_i  in  PRESC_W  tick divisor minus 1: one tick every presc_i+1 enabled cycles.
- en_i  in  N_CH  per-channel count enable.
- clr_i  in  N_CH  per-channel synchronous clear of counter, done, ovf.
- mode_i  in  2*N_CH  per-channel mode, channel k at bits [2k+1:2k]: 00 free-run, 01 periodic, 10 one-shot, 11 treated as free-run.
- cmp_i  in  N_CH*DATA_W  per-channel compare value, channel k at [k*DATA_W +: DATA_W].
- rstrb_i  in  N_CH  per-channel sample strobe.
- time_o  out  N_CH*DATA_W  per-channel sampled counter value (registered).
- match_o  out  N_CH  one-cycle match pulse (registered).
- done_o  out  N_CH  sticky one-shot completion.
- ovf_o  out  N_CH  sticky free-run wrap flag.

Behaviour:
- Reset (arst_n_i=0, async) clears: prescaler count, all counters, time_o, match_o, done_o, ovf_o. Release is synchronous to clk_i.
- cke_i=0 behaviour:
  - Every register holds its value, except match_o, which is driven 0.
  - All behaviour below applies only on cycles with cke_i=1.

Prescaler:
- Shared counter pcnt. Runs when any en_i bit is high; forced to 0 when en_i is all-zero.
- tick=1 in a cycle where pcnt>=presc_i; pcnt then reloads 0, otherwise increments.
- The >= comparison covers presc_i being lowered mid-count.
- presc_i=0: tick every cycle.

Channel k update, in priority order per clock edge:
1. clr_i[k]: cnt<=0, done<=0, ovf<=0, no match.
2. tick & en_i[k] & !done[k]:
   - if cnt==cmp, match_o[k]<=1 the next cycle (one cycle only);
   - free-run: cnt<=cnt+1 regardless of match. Wrap all-ones->0 sets ovf.
   - periodic: cnt==cmp -> cnt<=0, else cnt+1. Period = cmp+1 ticks; cmp=0 matches every tick. Never sets ovf.
   - one-shot: cnt==cmp -> cnt holds, done<=1; further ticks ignored until clr_i. Otherwise cnt+1.
3. Else cnt holds.

Sampling and mode changes:
- rstrb_i[k]=1 at edge t: time_o[k] captures cnt value present before edge t. The value is visible after edge t, i.e. 1-cycle latency.
- rstrb_i together with clr_i captures the pre-clear value.
- time_o is otherwise held indefinitely.
- mode_i/cmp_i changes take effect at the next tick. They do not clear cnt or flags.
- cmp below current cnt in periodic/one-shot: counter runs to wrap, then continues. ovf is not set in these modes.
- Channels are fully independent except for the shared tick.

Test Plan:
1. presc_i=0, ch0 free-run:
   - en_i[0]=1 for exactly 1003 edges;
   - then rstrb_i[0] pulse -> time_o[0]=1003 the cycle after the strobe edge;
   - other channels' time_o remain 0.
2. presc_i=3, ch1 periodic, cmp=4, enabled -> cnt sequence 0,1,2,3,4,0 with 4 cycles per step; match_o[1] one-cycle pulse every 20 cycles; ovf_o[1]=0.
3. presc_i=0, ch2 one-shot, cmp=10 -> cnt stops at 10; match_o[2] and done_o[2] rise after the 11th tick; cnt stays 10 for 100 more cycles; clr_i[2] -> cnt=0, done=0, counting resumes.
4. DATA_W=8, ch3 free-run, presc_i=0 -> after 256 ticks cnt=0 and ovf_o[3]=1; ovf_o[3] sticks until clr_i[3].
5. Same-cycle rstrb_i[0] and clr_i[0] with cnt=57 -> time_o[0]=57, cnt=0. Then arst_n_i pulsed low mid-count (asynchronous to clk) -> all outputs 0 immediately; counting restarts from 0 after release.
6. cke_i low for 50 cycles during counting -> cnt, pcnt, flags and time_o unchanged, match_o=0. Counting resumes exactly where it stopped once cke_i returns high.
